// File: rtl/xor_cipher_seq_ctrl_pkg.sv
// Shared types and sizing for the XOR cipher sequencing controller.
// State encodings are fixed because state_o exposes them for debug.
package cipher_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD_KEY  = 3'd1,
        LOAD_MSG  = 3'd2,
        ENCRYPT   = 3'd3,
        SHIFT_OUT = 3'd4,
        DEBUG_OUT = 3'd5
    } state_t;

    localparam int unsigned MSG_SIZE_DEF   = 64;
    localparam int unsigned KEY_SIZE_DEF   = 8;
    localparam int unsigned DEBUG_SIZE_DEF = 24;

    function automatic int unsigned cnt_width(input int unsigned size);
        return $clog2(size + 1);
    endfunction

    localparam int unsigned MSG_CNT_W   = cnt_width(MSG_SIZE_DEF);
    localparam int unsigned KEY_CNT_W   = cnt_width(KEY_SIZE_DEF);
    localparam int unsigned DEBUG_CNT_W = cnt_width(DEBUG_SIZE_DEF);

endpackage

// File: rtl/xor_cipher_seq_ctrl_sat_bit_counter.sv
// Saturating bit counter: clear has priority, and a clear together with
// increment loads 1 so a phase can count its first bit on entry.
module sat_bit_counter
    import cipher_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = KEY_CNT_W,
    parameter int unsigned LIMIT = KEY_SIZE_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt,
    output logic             at_limit
);

    assign at_limit = (cnt == WIDTH'(LIMIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= inc ? WIDTH'(1) : '0;
        end else if (inc && !at_limit) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

endmodule

// File: rtl/xor_cipher_seq_ctrl.sv
// Phase sequencer for the serial XOR cipher: key load, message load, encrypt,
// ciphertext readout and optional debug readout (enabled by CTRL_DEBUG_EN).
module xor_cipher_seq_ctrl
    import cipher_ctrl_pkg::*;
#(
    parameter int unsigned MSG_SIZE   = MSG_SIZE_DEF,
    parameter int unsigned KEY_SIZE   = KEY_SIZE_DEF,
    parameter int unsigned DEBUG_SIZE = DEBUG_SIZE_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       key_load_i,
    input  logic       msg_load_i,
    input  logic       enc_done_i,
    output logic       key_shift_o,
    output logic       msg_shift_o,
    output logic       enc_start_o,
    output logic       out_shift_o,
    output logic       dbg_shift_o,
    output logic       out_valid_o,
    output logic       key_ready_o,
    output logic [2:0] state_o
);

    localparam int unsigned KW = cnt_width(KEY_SIZE);
    localparam int unsigned MW = cnt_width(MSG_SIZE);

    state_t        state;
    logic          enc_first;
    logic          key_block;
    logic          idle, key_start, msg_start, msg_abort;
    logic [KW-1:0] key_cnt;
    logic [MW-1:0] msg_cnt, out_cnt;
    logic          key_at_limit, msg_at_limit, out_at_limit;

    always_comb begin
        idle        = (state == IDLE);
        key_start   = ena && idle && key_load_i && !key_block;
        msg_start   = ena && idle && !key_load_i && msg_load_i && key_at_limit;
        msg_abort   = (state == LOAD_MSG) && (key_load_i || !msg_load_i);
        key_shift_o = key_start ||
                      (ena && state == LOAD_KEY && key_load_i && !key_at_limit);
        msg_shift_o = msg_start ||
                      (ena && state == LOAD_MSG && !msg_abort && !msg_at_limit);
        enc_start_o = ena && state == ENCRYPT && enc_first;
        out_shift_o = ena && state == SHIFT_OUT && !out_at_limit;
    end

    // A completed key stays ready until the next key load actually starts.
    assign key_ready_o = key_at_limit;
    assign state_o     = state;

    sat_bit_counter #(.WIDTH(KW), .LIMIT(KEY_SIZE)) u_key_cnt (
        .clk(clk), .rst_n(rst_n), .clr(key_start), .inc(key_shift_o),
        .cnt(key_cnt), .at_limit(key_at_limit)
    );

    sat_bit_counter #(.WIDTH(MW), .LIMIT(MSG_SIZE)) u_msg_cnt (
        .clk(clk), .rst_n(rst_n), .clr(ena && (idle || msg_abort)), .inc(msg_shift_o),
        .cnt(msg_cnt), .at_limit(msg_at_limit)
    );

    sat_bit_counter #(.WIDTH(MW), .LIMIT(MSG_SIZE)) u_out_cnt (
        .clk(clk), .rst_n(rst_n), .clr(ena && idle), .inc(out_shift_o),
        .cnt(out_cnt), .at_limit(out_at_limit)
    );

`ifdef CTRL_DEBUG_EN
    localparam int unsigned DW = cnt_width(DEBUG_SIZE);
    logic [DW-1:0] dbg_cnt;
    logic          dbg_at_limit;

    assign dbg_shift_o = ena && state == DEBUG_OUT && !dbg_at_limit;

    sat_bit_counter #(.WIDTH(DW), .LIMIT(DEBUG_SIZE)) u_dbg_cnt (
        .clk(clk), .rst_n(rst_n), .clr(ena && idle), .inc(dbg_shift_o),
        .cnt(dbg_cnt), .at_limit(dbg_at_limit)
    );
`else
    assign dbg_shift_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            out_valid_o <= 1'b0;
            enc_first   <= 1'b0;
            key_block   <= 1'b0;
        end else if (ena) begin
            enc_first <= 1'b0;
            // Holding the key flag past a full key must not restart a load.
            if (!key_load_i) key_block <= 1'b0;
            case (state)
                IDLE: begin
                    if (key_start)      state <= LOAD_KEY;
                    else if (msg_start) state <= LOAD_MSG;
                end
                LOAD_KEY: begin
                    if (!key_load_i) begin
                        state <= IDLE;
                    end else if (key_cnt == KW'(KEY_SIZE - 1)) begin
                        state     <= IDLE;
                        key_block <= 1'b1;
                    end
                end
                LOAD_MSG: begin
                    if (msg_abort) begin
                        state <= IDLE;
                    end else if (msg_cnt == MW'(MSG_SIZE - 1)) begin
                        state     <= ENCRYPT;
                        enc_first <= 1'b1;
                    end
                end
                ENCRYPT: begin
                    if (enc_done_i) begin
                        state       <= SHIFT_OUT;
                        out_valid_o <= 1'b1;
                    end
                end
                SHIFT_OUT: begin
                    if (out_cnt == MW'(MSG_SIZE - 1)) begin
                        out_valid_o <= 1'b0;
`ifdef CTRL_DEBUG_EN
                        state <= DEBUG_OUT;
`else
                        state <= IDLE;
`endif
                    end
                end
`ifdef CTRL_DEBUG_EN
                DEBUG_OUT: begin
                    if (dbg_cnt == DW'(DEBUG_SIZE - 1)) state <= IDLE;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xor_cipher_seq_ctrl.sv
// Self-checking bench for xor_cipher_seq_ctrl: a behavioural reference model
// feeds a per-cycle scoreboard, and each scenario task checks pulse totals.
module tb_xor_cipher_seq_ctrl;

    localparam int MSG = 64;
    localparam int KEY = 8;
    localparam int DBG = 24;
`ifdef CTRL_DEBUG_EN
    localparam bit DBG_EN = 1'b1;
`else
    localparam bit DBG_EN = 1'b0;
`endif

    typedef logic [9:0] vec_t;

    logic clk = 1'b0;
    logic rst_n, ena, key_load, msg_load, enc_done;
    logic key_shift, msg_shift, enc_start, out_shift, dbg_shift, out_valid, key_ready;
    logic [2:0] state;

    int total = 0;
    int bad   = 0;
    int n_key = 0, n_msg = 0, n_enc = 0, n_out = 0, n_dbg = 0, n_valid = 0;

    vec_t exp_q[$];

    int m_state, m_kc, m_mc, m_oc, m_dc;
    bit m_valid, m_first, m_block;

    always #5 clk = ~clk;

    xor_cipher_seq_ctrl #(.MSG_SIZE(MSG), .KEY_SIZE(KEY), .DEBUG_SIZE(DBG)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .key_load_i(key_load), .msg_load_i(msg_load), .enc_done_i(enc_done),
        .key_shift_o(key_shift), .msg_shift_o(msg_shift), .enc_start_o(enc_start),
        .out_shift_o(out_shift), .dbg_shift_o(dbg_shift), .out_valid_o(out_valid),
        .key_ready_o(key_ready), .state_o(state)
    );

    task automatic model_reset();
        m_state = 0; m_kc = 0; m_mc = 0; m_oc = 0; m_dc = 0;
        m_valid = 0; m_first = 0; m_block = 0;
    endtask

    function automatic vec_t model_out();
        bit kr, ks, ms, es, os, ds;
        kr = (m_kc == KEY);
        ks = ena && ((m_state == 0 && key_load && !m_block) || (m_state == 1 && key_load));
        ms = ena && ((m_state == 0 && !key_load && msg_load && kr) ||
                     (m_state == 2 && msg_load && !key_load));
        es = ena && m_state == 3 && m_first;
        os = ena && m_state == 4;
        ds = ena && m_state == 5;
        return {ks, ms, es, os, ds, m_valid, kr, 3'(m_state)};
    endfunction

    task automatic model_step();
        if (ena) begin
            m_first = 0;
            if (!key_load) m_block = 0;
            case (m_state)
                0: begin
                    m_mc = 0; m_oc = 0; m_dc = 0;
                    if (key_load && !m_block) begin m_state = 1; m_kc = 1; end
                    else if (msg_load && m_kc == KEY) begin m_state = 2; m_mc = 1; end
                end
                1: begin
                    if (!key_load) m_state = 0;
                    else begin
                        m_kc++;
                        if (m_kc == KEY) begin m_state = 0; m_block = 1; end
                    end
                end
                2: begin
                    if (key_load || !msg_load) begin m_state = 0; m_mc = 0; end
                    else begin
                        m_mc++;
                        if (m_mc == MSG) begin m_state = 3; m_first = 1; end
                    end
                end
                3: if (enc_done) begin m_state = 4; m_valid = 1; end
                4: begin
                    m_oc++;
                    if (m_oc == MSG) begin m_valid = 0; m_oc = 0; m_state = DBG_EN ? 5 : 0; end
                end
                5: begin
                    m_dc++;
                    if (m_dc == DBG) begin m_dc = 0; m_state = 0; end
                end
                default: m_state = 0;
            endcase
        end
    endtask

    // One clock: drive inputs, queue the model's expectation, check the DUT at
    // the falling edge, then advance the model past the rising edge.
    task automatic tick(input logic k, input logic m, input logic d, input logic en);
        vec_t got, want;
        key_load = k; msg_load = m; enc_done = d; ena = en;
        exp_q.push_back(model_out());
        @(negedge clk);
        got  = {key_shift, msg_shift, enc_start, out_shift, dbg_shift, out_valid, key_ready, state};
        want = exp_q.pop_front();
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL scoreboard t=%0t got=%b expected=%b", $time, got, want);
        end
        n_key   += int'(key_shift);
        n_msg   += int'(msg_shift);
        n_enc   += int'(enc_start);
        n_out   += int'(out_shift);
        n_dbg   += int'(dbg_shift);
        n_valid += int'(out_valid);
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic load_key();
        repeat (KEY) tick(1'b1, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic drain();
        tick(1'b0, 1'b0, 1'b1, 1'b1);
        repeat (MSG + DBG + 2) tick(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        vec_t got;
        got = {key_shift, msg_shift, enc_start, out_shift, dbg_shift, out_valid, key_ready, state};
        total++;
        if (got !== 10'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%b expected=%b", got, 10'd0);
        end
    endtask

    task automatic test_no_key();
        int b = n_msg;
        repeat (5) tick(1'b0, 1'b1, 1'b0, 1'b1);
        total++;
        if (n_msg - b !== 0) begin bad++; $display("FAIL no_key_shifts got=%0d expected=0", n_msg - b); end
        total++;
        if (state !== 3'd0) begin bad++; $display("FAIL no_key_state got=%0d expected=0", state); end
        tick(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_key_load();
        int b = n_key;
        repeat (KEY) tick(1'b1, 1'b0, 1'b0, 1'b1);
        total++;
        if (n_key - b !== KEY) begin bad++; $display("FAIL key_shifts got=%0d expected=%0d", n_key - b, KEY); end
        total++;
        if (key_ready !== 1'b1) begin bad++; $display("FAIL key_ready got=%b expected=1", key_ready); end
        total++;
        if (state !== 3'd0) begin bad++; $display("FAIL key_state got=%0d expected=0", state); end
        repeat (2) tick(1'b1, 1'b0, 1'b0, 1'b1);
        total++;
        if (n_key - b !== KEY) begin bad++; $display("FAIL key_held_shifts got=%0d expected=%0d", n_key - b, KEY); end
        tick(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_full_pass();
        int bm, be, bo, bd, bv;
        load_key();
        bm = n_msg; be = n_enc; bo = n_out; bd = n_dbg; bv = n_valid;
        repeat (MSG) tick(1'b0, 1'b1, 1'b0, 1'b1);
        repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b1);
        drain();
        total++;
        if (n_msg - bm !== MSG) begin bad++; $display("FAIL pass_msg_shifts got=%0d expected=%0d", n_msg - bm, MSG); end
        total++;
        if (n_enc - be !== 1) begin bad++; $display("FAIL pass_enc_start got=%0d expected=1", n_enc - be); end
        total++;
        if (n_valid - bv !== MSG) begin bad++; $display("FAIL pass_valid_cycles got=%0d expected=%0d", n_valid - bv, MSG); end
        total++;
        if (n_out - bo !== MSG) begin bad++; $display("FAIL pass_out_shifts got=%0d expected=%0d", n_out - bo, MSG); end
        total++;
        if (n_dbg - bd !== (DBG_EN ? DBG : 0)) begin
            bad++; $display("FAIL pass_dbg_shifts got=%0d expected=%0d", n_dbg - bd, DBG_EN ? DBG : 0);
        end
        total++;
        if (state !== 3'd0 || key_ready !== 1'b1) begin
            bad++; $display("FAIL pass_end state=%0d key_ready=%b expected state=0 key_ready=1", state, key_ready);
        end
    endtask

    task automatic test_early_drop();
        int bm = n_msg, be = n_enc;
        repeat (30) tick(1'b0, 1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        total++;
        if (state !== 3'd0 || n_enc - be !== 0) begin
            bad++; $display("FAIL drop_abort state=%0d enc=%0d expected state=0 enc=0", state, n_enc - be);
        end
        total++;
        if (n_msg - bm !== 30) begin bad++; $display("FAIL drop_shifts got=%0d expected=30", n_msg - bm); end
        repeat (MSG) tick(1'b0, 1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        total++;
        if (n_enc - be !== 1 || state !== 3'd3) begin
            bad++; $display("FAIL drop_reload enc=%0d state=%0d expected enc=1 state=3", n_enc - be, state);
        end
        drain();
    endtask

    task automatic test_freeze();
        int bm = n_msg, be = n_enc, mid;
        repeat (20) tick(1'b0, 1'b1, 1'b0, 1'b1);
        mid = n_msg;
        repeat (10) tick(1'b0, 1'b1, 1'b0, 1'b0);
        total++;
        if (n_msg !== mid || state !== 3'd2) begin
            bad++; $display("FAIL freeze_hold shifts=%0d state=%0d expected shifts=%0d state=2", n_msg, state, mid);
        end
        repeat (MSG - 20) tick(1'b0, 1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        total++;
        if (n_msg - bm !== MSG || n_enc - be !== 1) begin
            bad++; $display("FAIL freeze_total shifts=%0d enc=%0d expected shifts=%0d enc=1", n_msg - bm, n_enc - be, MSG);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int be = n_enc;
        repeat (MSG) tick(1'b0, 1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        total++;
        if (n_enc - be !== 1) begin bad++; $display("FAIL b2b_enc_start got=%0d expected=1", n_enc - be); end
        tick(1'b0, 1'b0, 1'b1, 1'b1);
        repeat (10) tick(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_shift_out();
        int bm;
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL rst_pre_valid got=%b expected=1", out_valid); end
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || key_ready !== 1'b0 || state !== 3'd0 || out_shift !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid valid=%b key_ready=%b state=%0d out_shift=%b expected all 0",
                     out_valid, key_ready, state, out_shift);
        end
        exp_q.delete();
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bm = n_msg;
        repeat (5) tick(1'b0, 1'b1, 1'b0, 1'b1);
        total++;
        if (n_msg - bm !== 0) begin bad++; $display("FAIL rst_key_discarded got=%0d expected=0", n_msg - bm); end
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b0; key_load = 1'b0; msg_load = 1'b0; enc_done = 1'b0;
        model_reset();
        #2;
        test_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        test_no_key();
        test_key_load();
        test_full_pass();
        test_early_drop();
        test_freeze();
        test_back_to_back();
        test_reset_shift_out();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/xor_cipher_seq_ctrl.md
Name: xor_cipher_seq_ctrl

Overview:
Control FSM that sequences the serial XOR cipher datapath through four phases: key load, message load, encrypt, and serial ciphertext/debug readout.
- Owns all bit counters and phase state.
- Issues per-cycle shift strobes and an encrypt start pulse to the datapath, and produces the output-valid flag driven onto uo_out[1].
- Sits between the top-level pin decode (ui_in[1] key flag, ui_in[2] message flag) and the key/message/cipher shift registers.

Parameters:
- MSG_SIZE, 64, message/ciphertext length in bits.
- KEY_SIZE, 8, key length in bits; MSG_SIZE must be a multiple of KEY_SIZE.
- DEBUG_SIZE, 24, length of the debug readout stream in bits.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  global enable; low freezes the block.
- key_load_i  in  1  key-load flag (ui_in[1]).
- msg_load_i  in  1  message-load flag (ui_in[2]).
- enc_done_i  in  1  datapath encryption-complete pulse/level.
- key_shift_o  out  1  datapath shifts serial bit into key register this edge.
- msg_shift_o  out  1  datapath shifts serial bit into message register this edge.
- enc_start_o  out  1  one-cycle encrypt start pulse.
- out_shift_o  out  1  datapath shifts ciphertext MSB onto uo_out[0] this edge.
- dbg_shift_o  out  1  datapath shifts debug register onto uo_out[7] this edge.
- out_valid_o  out  1  ciphertext stream valid (uo_out[1]).
- key_ready_o  out  1  full key loaded.
- state_o  out  3  current FSM state encoding, for debug.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low rst_n.
- Reset state: FSM in IDLE; all counters 0; every output 0. This includes key_ready_o and state_o = IDLE.
- ena low: state, counters and registered outputs hold; all strobes (key_shift_o, msg_shift_o, out_shift_o, dbg_shift_o, enc_start_o) forced 0.
- Strobes are combinational from registered state and inputs, with zero latency. The datapath samples the serial bit on the same edge that the counter advances.
- States: IDLE=0, LOAD_KEY=1, LOAD_MSG=2, ENCRYPT=3, SHIFT_OUT=4, DEBUG_OUT=5.
- IDLE:
  - key_load_i=1 → go to LOAD_KEY; key_cnt cleared; key_ready_o drops; first bit shifted this cycle (key_cnt becomes 1).
  - Else msg_load_i=1 and key_ready_o=1 → go to LOAD_MSG with the first bit shifted.
  - msg_load_i=1 without key_ready_o → ignored; no strobe.
- LOAD_KEY: key_shift_o = key_load_i.
  - key_cnt increments per shifted bit.
  - Reaching KEY_SIZE sets key_ready_o and returns to IDLE, even if the flag stays high; further bits are not shifted.
  - key_load_i dropping early → IDLE; key_ready_o stays 0.
- LOAD_MSG: msg_shift_o = msg_load_i.
  - msg_cnt increments per shifted bit.
  - Reaching MSG_SIZE → ENCRYPT, with enc_start_o pulsed on the first ENCRYPT cycle.
  - msg_load_i dropping early → abort to IDLE; msg_cnt cleared.
  - key_load_i asserted mid-message → abort to IDLE; key load is not taken that cycle.
- Simultaneous key_load_i and msg_load_i in IDLE: key wins.
- ENCRYPT: wait for enc_done_i=1 → SHIFT_OUT. No timeout.
- SHIFT_OUT:
  - out_valid_o is registered high on entry; out_shift_o is high every cycle.
  - out_cnt counts to MSG_SIZE, then → DEBUG_OUT.
  - out_valid_o falls on the cycle after the last bit.
- DEBUG_OUT: dbg_shift_o is high for DEBUG_SIZE cycles, then → IDLE.
- Return to IDLE: msg_cnt and out_cnt cleared; key and key_ready_o retained, so re-encryption needs no key reload.
- Counter widths: $clog2(size+1). Counters saturate and never wrap.
- Reset asserted mid-operation: immediate return to the reset state; partial loads are discarded.

Optional Feature:
- Macro: CTRL_DEBUG_EN.
- Defined: DEBUG_OUT state present as described above.
- Undefined: SHIFT_OUT → IDLE directly; dbg_shift_o tied 0; debug counter not synthesised.

Decomposition:
- Package cipher_ctrl_pkg holds:
  - state enum with fixed 3-bit encodings;
  - default MSG_SIZE, KEY_SIZE, DEBUG_SIZE localparams;
  - counter width constants.
- One sub-module, sat_bit_counter: parameterised width/limit, with clear, increment-enable and at_limit flag. It is instantiated for key, message, output and debug counts.

Test Plan:
- Key load: reset, ena=1, key_load_i high 8 cycles → 8 key_shift_o pulses; key_ready_o=1 after the 8th edge; state_o=0.
- Full pass: key 0xA5, then msg_load_i high 64 cycles → 64 msg_shift_o pulses, one enc_start_o; after enc_done_i, out_valid_o high exactly 64 cycles, then 24 dbg_shift_o pulses, then IDLE.
- Early drop: msg_load_i high only 30 cycles → IDLE; no enc_start_o; a subsequent 64-bit load completes normally.
- No key: msg_load_i high straight after reset → no msg_shift_o; state stays IDLE.
- Freeze: ena low for 10 cycles mid-LOAD_MSG → strobes 0, msg_cnt holds; after resume, 64 total shifts.
- Reset in SHIFT_OUT: out_valid_o and key_ready_o drop immediately; state_o=0. With CTRL_DEBUG_EN undefined: dbg_shift_o is never asserted and SHIFT_OUT goes straight to IDLE.
